// File: rtl/uart_rx_fifo.sv
// UART receiver with parity/framing checks feeding a first-word-fall-through FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around mid-bit (adds 1 clock of latency).
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronised low
// START     | timing to mid start bit, rejecting glitches
// DATA      | sampling data bits LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, pushing or flagging the frame
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst_L,
    input  logic                               i_Rx_Serial,
    input  logic                               i_Rx_Ready,
    input  logic                               i_Err_Clr,
    output logic [DATA_BITS-1:0]               o_Rx_Data,
    output logic                               o_Rx_Valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count,
    output logic                               o_Parity_Err,
    output logic                               o_Frame_Err,
    output logic                               o_Overflow
);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int START_LOAD = CLKS_PER_BIT / 2;
`else
    localparam int START_LOAD = CLKS_PER_BIT / 2 - 1;
`endif
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] T_START  = TW'(START_LOAD);
    localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic          ODD      = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_S, STOP, WAIT_HIGH} state_t;

    state_t                 state, state_nxt;
    logic                   rx_meta, rx_sync, bit_smp, tick;
    logic [TW-1:0]          timer;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg, push_data;
    logic                   par_bad, push_q;
    logic                   load_half, load_full, shift_en, par_en;
    logic                   push_req, frame_err_set, parity_err_set;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic                   pop, full, wr_en, overflow_set;

    // Synchroniser resets to idle-high so a reset release never fakes a start edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_h1, rx_h2;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_sync;
            rx_h2 <= rx_h1;
        end
    end
    assign bit_smp = (rx_sync & rx_h1) | (rx_sync & rx_h2) | (rx_h1 & rx_h2);
`else
    assign bit_smp = rx_sync;
`endif

    assign tick = (timer == '0);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_sync) state_nxt = START;
            START:     if (tick) state_nxt = bit_smp ? IDLE : DATA;
            DATA:      if (tick && bit_cnt == LAST_BIT)
                           state_nxt = (PARITY != 0) ? PARITY_S : STOP;
            PARITY_S:  if (tick) state_nxt = STOP;
            STOP:      if (tick) state_nxt = bit_smp ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_sync) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_half      = (state == IDLE) && !rx_sync;
        load_full      = tick && (state == START || state == DATA || state == PARITY_S);
        shift_en       = tick && (state == DATA);
        par_en         = tick && (state == PARITY_S);
        push_req       = tick && (state == STOP) && bit_smp && !par_bad;
        frame_err_set  = tick && (state == STOP) && !bit_smp;
        parity_err_set = tick && (state == STOP) && par_bad;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            if (load_half)       timer <= T_START;
            else if (load_full)  timer <= T_FULL;
            else if (!tick)      timer <= timer - 1'b1;

            if (state == START)  bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;

            if (shift_en)        shreg <= {bit_smp, shreg[DATA_BITS-1:1]};

            if (load_half)       par_bad <= 1'b0;
            else if (par_en)     par_bad <= (^shreg) ^ bit_smp ^ ODD;

            push_q <= push_req;
            if (push_req)        push_data <= shreg;
        end
    end

    assign pop          = o_Rx_Valid && i_Rx_Ready;
    assign full         = (count == DEPTH_C);
    assign wr_en        = push_q && (!full || pop);
    assign overflow_set = push_q && full && !pop;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    assign o_Rx_Data    = mem[rd_ptr];
    assign o_Rx_Valid   = (count != '0);
    assign o_Fifo_Count = count;

    // Set has priority over a coincident clear.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overflow   <= 1'b0;
        end else begin
            o_Parity_Err <= parity_err_set | (o_Parity_Err & ~i_Err_Clr);
            o_Frame_Err  <= frame_err_set  | (o_Frame_Err  & ~i_Err_Clr);
            o_Overflow   <= overflow_set   | (o_Overflow   & ~i_Err_Clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 instance for data path, FIFO, framing, glitch and reset;
// even-parity instance for parity error handling.
module tb_uart_rx_fifo;
    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic [2:0] count_a, count_b;
    logic       perr_a, ferr_a, ovf_a, perr_b, ferr_b, ovf_b;

    int         tests = 0;
    int         fails = 0;
    int         vcyc  = 0;
    logic [7:0] cap[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_a), .i_Rx_Ready(ready_a),
        .i_Err_Clr(clr_a), .o_Rx_Data(data_a), .o_Rx_Valid(valid_a),
        .o_Fifo_Count(count_a), .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a),
        .o_Overflow(ovf_a));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_b), .i_Rx_Ready(ready_b),
        .i_Err_Clr(clr_b), .o_Rx_Data(data_b), .o_Rx_Valid(valid_b),
        .o_Fifo_Count(count_b), .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b),
        .o_Overflow(ovf_b));

    // Observe the handshake just before the rising edge, after the stimulus settled.
    always @(negedge clk) begin
        #2;
        if (valid_a) vcyc++;
        if (valid_a && ready_a) cap.push_back(data_a);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input logic sel_b, input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) rx_b = bits[i];
            else       rx_a = bits[i];
            wait_clks(CPB);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        drive_bits(1'b0, {2'b00, stop, d, 1'b0}, 10);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par);
        drive_bits(1'b1, {1'b0, 1'b1, par, d, 1'b0}, 11);
    endtask

    task automatic pulse_clr_a();
        clr_a = 1'b1;
        wait_clks(1);
        clr_a = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        wait_clks(4);
        check("rst_valid", valid_a, 0);
        check("rst_data",  data_a, 0);
        check("rst_count", count_a, 0);
        check("rst_flags", {perr_a, ferr_a, ovf_a}, 0);
        rst_n = 1'b1;
        wait_clks(10);

        // Back-to-back 8N1 frames with consumer always ready
        ready_a = 1'b1; cap.delete(); vcyc = 0;
        send_a(8'hA5, 1'b1);
        send_a(8'h3C, 1'b1);
        wait_clks(10);
        check("b2b_n", cap.size(), 2);
        check("b2b_d0", cap[0], 8'hA5);
        check("b2b_d1", cap[1], 8'h3C);
        check("b2b_vcyc", vcyc, 2);
        check("b2b_flags", {perr_a, ferr_a, ovf_a}, 0);

        // Even parity: 0x07 needs parity 1, send 0 -> discard
        send_b(8'h07, 1'b0);
        wait_clks(5);
        check("par_err", perr_b, 1);
        check("par_count", count_b, 0);
        clr_b = 1'b1; wait_clks(1); clr_b = 1'b0; wait_clks(1);
        check("par_clr", perr_b, 0);
        send_b(8'h07, 1'b1);
        wait_clks(5);
        check("par_ok_count", count_b, 1);
        check("par_ok_data", data_b, 8'h07);
        check("par_ok_flags", {perr_b, ferr_b, ovf_b}, 0);

        // Framing error followed by a break held for 3 bit times
        cap.delete(); vcyc = 0;
        send_a(8'hF0, 1'b0);
        wait_clks(3 * CPB);
        check("ferr_set", ferr_a, 1);
        check("ferr_nocap", cap.size(), 0);
        check("ferr_vcyc", vcyc, 0);
        rx_a = 1'b1;
        wait_clks(CPB);
        send_a(8'h55, 1'b1);
        wait_clks(10);
        check("ferr_rec_n", cap.size(), 1);
        check("ferr_rec_d", cap[0], 8'h55);
        check("ferr_sticky", ferr_a, 1);
        pulse_clr_a();
        check("ferr_clr", ferr_a, 0);

        // Overflow with consumer stalled
        ready_a = 1'b0;
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
        wait_clks(10);
        check("ovf_count", count_a, 4);
        check("ovf_flag", ovf_a, 1);
        check("ovf_head", data_a, 8'h01);
        cap.delete();
        ready_a = 1'b1;
        wait_clks(10);
        check("drain_n", cap.size(), 4);
        check("drain_d0", cap[0], 8'h01);
        check("drain_d1", cap[1], 8'h02);
        check("drain_d2", cap[2], 8'h03);
        check("drain_d3", cap[3], 8'h04);
        check("drain_count", count_a, 0);
        pulse_clr_a();
        check("ovf_clr", ovf_a, 0);

        // Short low glitch is rejected, receiver still works afterwards
        cap.delete();
        rx_a = 1'b0;
        wait_clks(CPB / 4);
        rx_a = 1'b1;
        wait_clks(2 * CPB);
        check("glitch_n", cap.size(), 0);
        check("glitch_count", count_a, 0);
        check("glitch_flags", {perr_a, ferr_a, ovf_a}, 0);
        send_a(8'h81, 1'b1);
        wait_clks(10);
        check("glitch_rec_n", cap.size(), 1);
        check("glitch_rec_d", cap[0], 8'h81);

        // Reset mid-frame with stored entry and sticky flag
        ready_a = 1'b0;
        send_a(8'h42, 1'b1);
        send_a(8'h00, 1'b0);
        rx_a = 1'b1;
        wait_clks(CPB);
        check("pre_rst_count", count_a, 1);
        check("pre_rst_ferr", ferr_a, 1);
        rx_a = 1'b0;
        wait_clks(4 * CPB + CPB / 2);
        rst_n = 1'b0;
        wait_clks(2);
        check("midrst_valid", valid_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_count", count_a, 0);
        check("midrst_flags", {perr_a, ferr_a, ovf_a}, 0);
        rx_a = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(CPB);
        cap.delete();
        ready_a = 1'b1;
        send_a(8'h99, 1'b1);
        wait_clks(10);
        check("postrst_n", cap.size(), 1);
        check("postrst_d", cap[0], 8'h99);
        check("postrst_flags", {perr_a, ferr_a, ovf_a}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
